// File: rtl/acc_drain_quant.sv
// Drains accumulator rows 0..DEPTH-1, requantizes each column (scale, rounding shift, int8 saturate); ACC_DRAIN_RELU_EN clamps negatives to 0.
// First out_valid 4 cycles after start, then one row per cycle; out_valid & ~out_ready freezes the FSM, acc_addr and every stage.
module acc_drain_quant #(
   parameter int ARRAY_COL   = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int OUT_WIDTH   = 8,
   parameter int DEPTH       = 16,
   parameter int MULT_WIDTH  = 16,
   parameter int SHIFT_WIDTH = 5,
   parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic signed [MULT_WIDTH-1:0]   mult,
   input  logic [SHIFT_WIDTH-1:0]         shift,
   output logic                           busy,
   output logic                           done,
   output logic [ADDR_WIDTH-1:0]          acc_addr,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_rd_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ARRAY_COL*OUT_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0]          out_row,
   output logic                           out_last
);

   typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

   localparam int PW = ACC_WIDTH + MULT_WIDTH;
   localparam int RW = ARRAY_COL * ACC_WIDTH;
   localparam int QW = ARRAY_COL * OUT_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);
   localparam logic signed [PW-1:0]  SAT_MAX  = PW'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [PW-1:0]  SAT_MIN  = ~SAT_MAX;

   state_t                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic signed [MULT_WIDTH-1:0]  mult_q;
   logic [SHIFT_WIDTH-1:0]        shift_q;
   logic                          stall, fire, last_hs;

   logic                          bus_vld, skid_vld, cap_vld, mul_vld;
   logic [ADDR_WIDTH-1:0]         bus_row, skid_row, cap_row, mul_row;
   logic [RW-1:0]                 skid_dat, cap_dat;
   logic [ARRAY_COL*PW-1:0]       mul_dat, mul_d;
   logic [QW-1:0]                 quant_d;
   logic signed [PW-1:0]          a_ext, m_ext, p, rnd, r;
   logic [OUT_WIDTH-1:0]          q;

   assign stall    = out_valid & ~out_ready;
   assign last_hs  = out_valid & out_ready & out_last;
   assign acc_addr = addr_q;

   // Row 0 is already on acc_addr while idle, so the start cycle itself issues it.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      fire    = 1'b0;
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      unique case (state_q)
         IDLE:  fire = start;
         ISSUE: fire = ~stall;
         FLUSH: if (last_hs) state_d = DONE;
         DONE:  begin
            state_d = IDLE;
            addr_d  = '0;
         end
         default: state_d = IDLE;
      endcase
      if (fire) begin
         if (addr_q == LAST_ROW) begin
            state_d = FLUSH;
         end else begin
            state_d = ISSUE;
            addr_d  = addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         mult_q  <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         if (state_q == IDLE && start) begin
            mult_q  <= mult;
            shift_q <= shift;
         end
      end
   end

   always_comb begin
      mul_d = '0;
      a_ext = '0;
      m_ext = PW'(mult_q);
      for (int c = 0; c < ARRAY_COL; c++) begin
         a_ext = PW'($signed(cap_dat[c*ACC_WIDTH +: ACC_WIDTH]));
         mul_d[c*PW +: PW] = a_ext * m_ext;
      end
   end

   // A zero rounding constant makes shift==0 a plain pass-through.
   always_comb begin
      quant_d = '0;
      p       = '0;
      r       = '0;
      q       = '0;
      rnd     = (shift_q == '0) ? '0 : (PW'(1) << (shift_q - SHIFT_WIDTH'(1)));
      for (int c = 0; c < ARRAY_COL; c++) begin
         p = $signed(mul_dat[c*PW +: PW]);
         r = (p + rnd) >>> shift_q;
         if (r > SAT_MAX)      q = SAT_MAX[OUT_WIDTH-1:0];
         else if (r < SAT_MIN) q = SAT_MIN[OUT_WIDTH-1:0];
         else                  q = r[OUT_WIDTH-1:0];
`ifdef ACC_DRAIN_RELU_EN
         if (q[OUT_WIDTH-1]) q = '0;
`endif
         quant_d[c*OUT_WIDTH +: OUT_WIDTH] = q;
      end
   end

   // The bank keeps reading the frozen address during a stall, so the row already
   // on acc_rd_data when the stall begins is parked in the skid register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_vld   <= 1'b0;
         bus_row   <= '0;
         skid_vld  <= 1'b0;
         skid_row  <= '0;
         skid_dat  <= '0;
         cap_vld   <= 1'b0;
         cap_row   <= '0;
         cap_dat   <= '0;
         mul_vld   <= 1'b0;
         mul_row   <= '0;
         mul_dat   <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         bus_vld <= fire;
         if (fire) bus_row <= addr_q;
         if (stall) begin
            if (bus_vld && !skid_vld) begin
               skid_vld <= 1'b1;
               skid_row <= bus_row;
               skid_dat <= acc_rd_data;
            end
         end else begin
            skid_vld  <= 1'b0;
            cap_vld   <= skid_vld | bus_vld;
            cap_row   <= skid_vld ? skid_row : bus_row;
            cap_dat   <= skid_vld ? skid_dat : acc_rd_data;
            mul_vld   <= cap_vld;
            mul_row   <= cap_row;
            mul_dat   <= mul_d;
            out_valid <= mul_vld;
            out_row   <= mul_row;
            out_data  <= quant_d;
            out_last  <= mul_vld && (mul_row == LAST_ROW);
         end
      end
   end

endmodule

// File: tb/tb_acc_drain_quant.sv
// Directed bench for acc_drain_quant with a registered-read accumulator bank model.
module tb_acc_drain_quant;
   localparam int AC = 16;
   localparam int AW = 32;
   localparam int OW = 8;
   localparam int D  = 16;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic signed [15:0] mult;
   logic [4:0]        shift;
   logic              busy, done, out_valid, out_last;
   logic [3:0]        acc_addr, out_row;
   logic [AC*AW-1:0]  acc_rd_data;
   logic [AC*OW-1:0]  out_data;
   logic [AC*AW-1:0]  bank [D];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int last_hs_cyc = -1;
   logic [AC*OW-1:0] data_q[$];
   int               row_q[$];
   bit               last_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) acc_rd_data <= bank[acc_addr];

   acc_drain_quant dut (
      .clk(clk), .rst(rst), .start(start), .mult(mult), .shift(shift),
      .busy(busy), .done(done), .acc_addr(acc_addr), .acc_rd_data(acc_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_last(out_last)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Records the handshake and done of the current cycle, then advances one clock.
   task automatic tick();
      if (out_valid && out_ready) begin
         data_q.push_back(out_data);
         row_q.push_back(int'(out_row));
         last_q.push_back(out_last);
         if (out_last) last_hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_rec();
      data_q.delete();
      row_q.delete();
      last_q.delete();
      done_cnt = 0;
      done_cyc = -1;
      last_hs_cyc = -1;
   endtask

   task automatic pulse_start(input logic signed [15:0] m, input logic [4:0] s);
      mult  = m;
      shift = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drain(input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic fill_const(input int v);
      for (int rr = 0; rr < D; rr++)
         for (int c = 0; c < AC; c++) bank[rr][c*AW +: AW] = AW'(v);
   endtask

   task automatic fill_ramp();
      for (int rr = 0; rr < D; rr++)
         for (int c = 0; c < AC; c++) bank[rr][c*AW +: AW] = AW'(rr*7 + c - 50);
   endtask

   function automatic logic [AC*OW-1:0] exp_ramp(input int rr);
      logic [AC*OW-1:0] e;
      e = '0;
      for (int c = 0; c < AC; c++) e[c*OW +: OW] = OW'(rr*7 + c - 50);
      return e;
   endfunction

   task automatic run_row0(input logic signed [15:0] m, input logic [4:0] s,
                           output logic [AC*OW-1:0] row0, output bit ok);
      bit to;
      clear_rec();
      out_ready = 1'b1;
      pulse_start(m, s);
      drain(100, to);
      ok = !to && row_q.size() == 16 && row_q[0] == 0;
      row0 = (data_q.size() > 0) ? data_q[0] : 'x;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      n_tests++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL rst_last: got %b want 0", out_last); end
      n_tests++; if (out_row !== 4'd0)   begin n_fail++; $display("FAIL rst_row: got %0d want 0", out_row); end
      n_tests++; if (out_data !== '0)    begin n_fail++; $display("FAIL rst_data: got %h want 0", out_data); end
      n_tests++; if (acc_addr !== 4'd0)  begin n_fail++; $display("FAIL rst_addr: got %0d want 0", acc_addr); end
      rst = 1'b0;
      tick();
      tick();
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0/0", busy, out_valid);
      end
   endtask

   task automatic test_saturate();
      bit to;
      int lat, bad;
      logic [AC*OW-1:0] e;
      fill_const(1000);
      e = {AC{8'h7f}};
      clear_rec();
      out_ready = 1'b1;
      pulse_start(16'sd16384, 5'd14);
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL sat_latency: got %0d want 4", lat); end
      drain(100, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL sat_timeout: no done within budget"); end
      n_tests++; if (row_q.size() != 16) begin n_fail++; $display("FAIL sat_rows: got %0d want 16", row_q.size()); end
      bad = 0;
      for (int i = 0; i < row_q.size(); i++)
         if (row_q[i] != i || data_q[i] !== e || last_q[i] != (i == 15)) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_data: %0d bad rows want 0", bad); end
      n_tests++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
         n_fail++; $display("FAIL sat_done: count=%0d at %0d, last hs %0d want 1 pulse next cycle", done_cnt, done_cyc, last_hs_cyc);
      end
   endtask

   task automatic test_round();
      logic [AC*OW-1:0] row0, e;
      bit ok;
      fill_const(0);
      bank[0][0*AW +: AW] = 32'sd3;
      bank[0][1*AW +: AW] = -32'sd3;
      bank[0][2*AW +: AW] = 32'sd5;
      bank[0][3*AW +: AW] = -32'sd5;
      run_row0(16'sd1, 5'd1, row0, ok);
      e = '0;
      e[0*OW +: OW] = 8'h02; e[1*OW +: OW] = 8'hff; e[2*OW +: OW] = 8'h03; e[3*OW +: OW] = 8'hfe;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL round_pass1: pass incomplete"); end
      n_tests++; if (row0 !== e) begin n_fail++; $display("FAIL round_shift1: got %h want %h", row0, e); end

      fill_const(0);
      bank[0][0*AW +: AW] = -32'sd1000;
      bank[0][1*AW +: AW] = 32'sd100;
      bank[0][2*AW +: AW] = 32'sd127;
      bank[0][3*AW +: AW] = 32'sd128;
      bank[0][4*AW +: AW] = -32'sd128;
      bank[0][5*AW +: AW] = -32'sd129;
      run_row0(16'sd1, 5'd0, row0, ok);
      e = '0;
      e[0*OW +: OW] = 8'h80; e[1*OW +: OW] = 8'h64; e[2*OW +: OW] = 8'h7f;
      e[3*OW +: OW] = 8'h7f; e[4*OW +: OW] = 8'h80; e[5*OW +: OW] = 8'h80;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL round_pass2: pass incomplete"); end
      n_tests++; if (row0 !== e) begin n_fail++; $display("FAIL round_shift0: got %h want %h", row0, e); end

      fill_const(0);
      bank[0][0*AW +: AW] = 32'sd5;
      bank[0][1*AW +: AW] = 32'sd7;
      bank[0][2*AW +: AW] = -32'sd6;
      run_row0(-16'sd2, 5'd2, row0, ok);
      e = '0;
      e[0*OW +: OW] = 8'hfe; e[1*OW +: OW] = 8'hfd; e[2*OW +: OW] = 8'h03;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL round_pass3: pass incomplete"); end
      n_tests++; if (row0 !== e) begin n_fail++; $display("FAIL round_negmult: got %h want %h", row0, e); end
   endtask

   task automatic test_backpressure();
      bit to;
      int i, bad;
      fill_ramp();
      clear_rec();
      out_ready = 1'b1;
      pulse_start(16'sd1, 5'd0);
      i = 0;
      while (!(out_valid && out_row == 4'd3) && i < 40) begin
         tick();
         i++;
      end
      n_tests++; if (i >= 40) begin n_fail++; $display("FAIL bp_row3: row 3 never became valid"); end
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_row !== 4'd3 || out_data !== exp_ramp(3) || acc_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL bp_frozen%0d: valid=%b row=%0d addr=%0d data=%h want 1/3/7/%h",
                     k, out_valid, out_row, acc_addr, out_data, exp_ramp(3));
         end
         tick();
      end
      out_ready = 1'b1;
      drain(100, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
      n_tests++; if (row_q.size() != 16) begin n_fail++; $display("FAIL bp_rows: got %0d want 16", row_q.size()); end
      bad = 0;
      for (int j = 0; j < row_q.size(); j++)
         if (row_q[j] != j || data_q[j] !== exp_ramp(j)) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_order: %0d bad rows want 0", bad); end
   endtask

   task automatic test_start_busy();
      bit to;
      int bad;
      fill_const(40);
      clear_rec();
      out_ready = 1'b1;
      pulse_start(16'sd2, 5'd0);
      repeat (4) tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid: got %b want 1", busy); end
      mult  = 16'sd3;
      shift = 5'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      drain(100, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL sb_timeout: no done within budget"); end
      bad = 0;
      for (int j = 0; j < row_q.size(); j++)
         if (row_q[j] != j || data_q[j] !== {AC{8'h50}}) bad++;
      n_tests++;
      if (row_q.size() != 16 || bad != 0) begin
         n_fail++; $display("FAIL sb_rows: got %0d rows, %0d bad, want 16 rows of 0x50", row_q.size(), bad);
      end
      bad = 0;
      repeat (8) begin
         tick();
         if (out_valid || busy) bad++;
      end
      n_tests++;
      if (bad != 0 || done_cnt != 1) begin
         n_fail++; $display("FAIL sb_no_second_pass: active cycles=%0d done=%0d want 0/1", bad, done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int i;
      fill_ramp();
      clear_rec();
      out_ready = 1'b1;
      pulse_start(16'sd1, 5'd0);
      i = 0;
      while (!(out_valid && out_row == 4'd7) && i < 40) begin
         tick();
         i++;
      end
      n_tests++; if (i >= 40) begin n_fail++; $display("FAIL rm_row7: row 7 never became valid"); end
      rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_row !== 4'd0 || out_last !== 1'b0) begin
         n_fail++; $display("FAIL rm_outputs: valid=%b row=%0d last=%b data=%h want all 0", out_valid, out_row, out_last, out_data);
      end
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || acc_addr !== 4'd0) begin
         n_fail++; $display("FAIL rm_ctrl: busy=%b done=%b addr=%0d want 0/0/0", busy, done, acc_addr);
      end
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL rm_no_done: got %0d pulses want 0", done_cnt); end
      n_tests++; if (row_q.size() != 7) begin n_fail++; $display("FAIL rm_rows_before: got %0d want 7", row_q.size()); end
      clear_rec();
      pulse_start(16'sd1, 5'd0);
      drain(100, to);
      n_tests++;
      if (to || row_q.size() != 16 || row_q[0] != 0 || data_q[0] !== exp_ramp(0) || data_q[15] !== exp_ramp(15)) begin
         n_fail++; $display("FAIL rm_restart: timeout=%0d rows=%0d want full pass from row 0", to, row_q.size());
      end
   endtask

   task automatic test_relu();
      logic [AC*OW-1:0] row0, e;
      bit ok;
      fill_const(0);
      bank[0][0*AW +: AW] = -32'sd50;
      run_row0(16'sd1, 5'd0, row0, ok);
      e = '0;
`ifndef ACC_DRAIN_RELU_EN
      e[0*OW +: OW] = 8'hce;
`endif
      n_tests++; if (!ok) begin n_fail++; $display("FAIL relu_pass: pass incomplete"); end
      n_tests++; if (row0 !== e) begin n_fail++; $display("FAIL relu_neg: got %h want %h", row0, e); end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      mult = '0;
      shift = '0;
      for (int rr = 0; rr < D; rr++) bank[rr] = '0;
      test_reset();
      test_saturate();
      test_round();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
      test_relu();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
